// File: rtl/usb_pkg.sv
// Shared USB definitions: PIDs, CRC16 constants and TX scheduler states.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_ACK   = 4'h2,
        PID_NAK   = 4'hA,
        PID_STALL = 4'hE,
        PID_DATA0 = 4'h3,
        PID_DATA1 = 4'hB
    } pid_t;

    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SEND_PID,
        TX_SEND_DATA,
        TX_SEND_CRC_LO,
        TX_SEND_CRC_HI,
        TX_LAST
    } tx_state_t;

    // Reflected CRC16 update over one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++)
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 accumulator; clear has priority over enable.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (clear)
            crc <= CRC16_INIT;
        else if (enable)
            crc <= crc16_byte(crc, data);
    end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Packet-level USB TX controller: handshake/data arbitration, PID, payload
// streaming with one-byte prefetch, CRC16 trailer and inter-packet delay.
module usb_tx_scheduler
    import usb_pkg::*;
#(
    parameter  int IPD_CLKS = 8,
    parameter  int MAX_LEN  = 64,
    localparam int LEN_W    = $clog2(MAX_LEN + 1),
    localparam int ADDR_W   = $clog2(MAX_LEN),
    localparam int IPD_W    = $clog2(IPD_CLKS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_active,
    input  logic              hs_req,
    input  logic [3:0]        hs_pid,
    output logic              hs_done,
    input  logic              dp_req,
    input  logic [3:0]        dp_pid,
    input  logic [LEN_W-1:0]  dp_len,
    output logic              dp_done,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy
);

    tx_state_t         state, state_n;
    logic [7:0]        tx_data_n;
    logic              tx_valid_n, hs_done_n, dp_done_n, rd_en_n;
    logic [ADDR_W-1:0] rd_addr_n;
    logic [3:0]        pid_q, pid_n;
    logic              is_dp, is_dp_n;
    logic [LEN_W-1:0]  len_q, len_n, nbytes, nbytes_n, len_clamp, nb_inc;
    logic [IPD_W-1:0]  ipd, ipd_n;
    logic              crc_clr, load_byte;
    logic [15:0]       crc;

    assign len_clamp = (dp_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : dp_len;
    assign nb_inc    = nbytes + 1'b1;
    assign busy      = (state != TX_IDLE);

    usb_crc16 u_crc (
        .clk    (clk),
        .clear  (crc_clr | ~reset),
        .enable (load_byte),
        .data   (rd_data),
        .crc    (crc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= TX_IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            hs_done  <= 1'b0;
            dp_done  <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            pid_q    <= 4'h0;
            is_dp    <= 1'b0;
            len_q    <= '0;
            nbytes   <= '0;
            ipd      <= IPD_W'(IPD_CLKS);
        end else begin
            state    <= state_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            hs_done  <= hs_done_n;
            dp_done  <= dp_done_n;
            rd_en    <= rd_en_n;
            rd_addr  <= rd_addr_n;
            pid_q    <= pid_n;
            is_dp    <= is_dp_n;
            len_q    <= len_n;
            nbytes   <= nbytes_n;
            ipd      <= ipd_n;
        end
    end

    always_comb begin
        state_n    = state;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        hs_done_n  = 1'b0;
        dp_done_n  = 1'b0;
        rd_en_n    = 1'b0;
        rd_addr_n  = rd_addr;
        pid_n      = pid_q;
        is_dp_n    = is_dp;
        len_n      = len_q;
        nbytes_n   = nbytes;
        crc_clr    = 1'b0;
        load_byte  = 1'b0;
        ipd_n      = rx_active ? IPD_W'(IPD_CLKS) : ((ipd != '0) ? ipd - 1'b1 : ipd);

        case (state)
            TX_IDLE: begin
                if (ipd == '0 && !rx_active && (hs_req || dp_req)) begin
                    crc_clr    = 1'b1;
                    nbytes_n   = '0;
                    tx_valid_n = 1'b1;
                    state_n    = TX_SEND_PID;
                    if (hs_req) begin
                        pid_n   = hs_pid;
                        is_dp_n = 1'b0;
                        len_n   = '0;
                    end else begin
                        pid_n   = dp_pid;
                        is_dp_n = 1'b1;
                        len_n   = len_clamp;
                        if (len_clamp != '0) begin
                            rd_en_n   = 1'b1;
                            rd_addr_n = '0;
                        end
                    end
                    tx_data_n = {~pid_n, pid_n};
                end
            end
            TX_SEND_PID: begin
                if (tx_ready) begin
                    if (!is_dp) begin
                        state_n = TX_LAST;
                    end else if (len_q == '0) begin
                        tx_data_n = ~crc[7:0];
                        state_n   = TX_SEND_CRC_LO;
                    end else begin
                        load_byte = 1'b1;
                        state_n   = TX_SEND_DATA;
                    end
                end
            end
            TX_SEND_DATA: begin
                if (tx_ready) begin
                    if (nbytes == len_q) begin
                        tx_data_n = ~crc[7:0];
                        state_n   = TX_SEND_CRC_LO;
                    end else begin
                        load_byte = 1'b1;
                    end
                end
            end
            TX_SEND_CRC_LO: begin
                if (tx_ready) begin
                    tx_data_n = ~crc[15:8];
                    state_n   = TX_SEND_CRC_HI;
                end
            end
            TX_SEND_CRC_HI: begin
                if (tx_ready)
                    state_n = TX_LAST;
            end
            TX_LAST: begin
                tx_valid_n = 1'b0;
                hs_done_n  = ~is_dp;
                dp_done_n  = is_dp;
                ipd_n      = IPD_W'(IPD_CLKS);
                state_n    = TX_IDLE;
            end
            default: state_n = TX_IDLE;
        endcase

        // Loading a byte also issues the read for the following one, so it
        // lands in rd_data long before the transceiver asks for it.
        if (load_byte) begin
            tx_data_n = rd_data;
            nbytes_n  = nb_inc;
            if (nb_inc < len_q) begin
                rd_en_n   = 1'b1;
                rd_addr_n = rd_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler: vector table plus corner sequences.
module tb_usb_tx_scheduler;

    localparam int IPD_CLKS = 8;
    localparam int MAX_LEN  = 64;

    logic       clk = 1'b0;
    logic       reset, rx_active, hs_req, dp_req, tx_ready;
    logic [3:0] hs_pid, dp_pid;
    logic [6:0] dp_len;
    logic [7:0] rd_data;
    logic       hs_done, dp_done, rd_en, tx_valid, busy;
    logic [5:0] rd_addr;
    logic [7:0] tx_data;

    usb_tx_scheduler #(.IPD_CLKS(IPD_CLKS), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .reset(reset), .rx_active(rx_active),
        .hs_req(hs_req), .hs_pid(hs_pid), .hs_done(hs_done),
        .dp_req(dp_req), .dp_pid(dp_pid), .dp_len(dp_len), .dp_done(dp_done),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:63];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int tests = 0, fails = 0;
    int hs_cnt = 0, dp_cnt = 0, rd_multi = 0;
    logic rd_en_prev = 1'b0;
    logic [5:0] rd_q[$];

    always @(negedge clk) begin
        if (rd_en) rd_q.push_back(rd_addr);
        if (rd_en && rd_en_prev) rd_multi++;
        rd_en_prev = rd_en;
        if (hs_done) hs_cnt++;
        if (dp_done) dp_cnt++;
    end

    typedef struct {
        logic       hs;
        logic [3:0] pid;
        logic [6:0] len;
        logic [7:0] pid_byte;
    } vec_t;
    vec_t vecs[4];

    logic [7:0] exp_b [0:79];
    int exp_n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ mem[i][b];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        return c;
    endfunction

    task automatic build(input logic [7:0] pb, input logic dp, input int len);
        logic [15:0] c;
        exp_b[0] = pb;
        exp_n = 1;
        if (dp) begin
            for (int i = 0; i < len; i++) exp_b[1+i] = mem[i];
            c = crc_model(len);
            exp_b[len+1] = ~c[7:0];
            exp_b[len+2] = ~c[15:8];
            exp_n = len + 3;
        end
    endtask

    // Waits for the packet, handshakes every expected byte, checks EOP/done.
    task automatic xfer(input string tag, input logic dp, output int wt);
        wt = 0;
        while (!tx_valid && wt < 300) begin @(negedge clk); wt++; end
        chk({tag, " sync"}, tx_valid, 1);
        for (int k = 0; k < exp_n; k++) begin
            repeat (3) @(negedge clk);
            chk($sformatf("%s byte%0d", tag, k), tx_data, exp_b[k]);
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        chk({tag, " last_hold"}, tx_valid, 1);
        @(negedge clk);
        chk({tag, " eop"}, tx_valid, 0);
        chk({tag, " done"}, dp ? dp_done : hs_done, 1);
        chk({tag, " other_done"}, dp ? hs_done : dp_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wt, eff, viol;
        vecs[0] = '{1'b1, 4'h2, 7'd0,  8'hD2};
        vecs[1] = '{1'b0, 4'h3, 7'd0,  8'hC3};
        vecs[2] = '{1'b0, 4'hB, 7'd4,  8'h4B};
        vecs[3] = '{1'b0, 4'h3, 7'd70, 8'hC3};
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);

        reset = 1'b0; rx_active = 1'b0; hs_req = 1'b0; dp_req = 1'b0;
        tx_ready = 1'b0; hs_pid = 4'h0; dp_pid = 4'h0; dp_len = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst tx_valid", tx_valid, 0);
        chk("rst tx_data", tx_data, 0);
        chk("rst dones", {hs_done, dp_done}, 0);
        chk("rst rd", {rd_en, rd_addr}, 0);
        chk("rst busy", busy, 0);
        reset = 1'b1;

        for (int v = 0; v < 4; v++) begin
            eff = (vecs[v].len > 7'(MAX_LEN)) ? MAX_LEN : int'(vecs[v].len);
            build(vecs[v].pid_byte, ~vecs[v].hs, eff);
            rd_q.delete();
            if (vecs[v].hs) begin hs_req = 1'b1; hs_pid = vecs[v].pid; end
            else begin dp_req = 1'b1; dp_pid = vecs[v].pid; dp_len = vecs[v].len; end
            xfer($sformatf("vec%0d", v), ~vecs[v].hs, wt);
            hs_req = 1'b0; dp_req = 1'b0;
            chk($sformatf("vec%0d ipd_wait", v), wt, IPD_CLKS + 1);
            chk($sformatf("vec%0d rd_count", v), rd_q.size(), vecs[v].hs ? 0 : eff);
            for (int i = 0; i < rd_q.size(); i++)
                chk($sformatf("vec%0d rd_addr%0d", v, i), rd_q[i], i);
        end

        // Both requests together: handshake first, data after a full IPD.
        hs_req = 1'b1; hs_pid = 4'hE;
        dp_req = 1'b1; dp_pid = 4'h3; dp_len = 7'd1;
        build(8'h1E, 1'b0, 0);
        xfer("stall", 1'b0, wt);
        hs_req = 1'b0;
        chk("stall ipd_wait", wt, IPD_CLKS + 1);
        build(8'hC3, 1'b1, 1);
        xfer("d0len1", 1'b1, wt);
        dp_req = 1'b0;
        chk("d0len1 gap", wt, IPD_CLKS + 1);

        // Bus RX activity holds off the handshake until IPD after it ends.
        rx_active = 1'b1; hs_req = 1'b1; hs_pid = 4'hA;
        viol = 0;
        repeat (50) begin @(negedge clk); if (tx_valid) viol++; end
        chk("rx hold_off", viol, 0);
        rx_active = 1'b0;
        build(8'h5A, 1'b0, 0);
        xfer("nak", 1'b0, wt);
        hs_req = 1'b0;
        chk("nak ipd_wait", wt, IPD_CLKS + 1);

        // Reset during payload: packet aborted silently, then restarted.
        dp_req = 1'b1; dp_pid = 4'hB; dp_len = 7'd4;
        wt = 0;
        while (!tx_valid && wt < 300) begin @(negedge clk); wt++; end
        chk("abort sync", tx_valid, 1);
        repeat (2) @(negedge clk);
        tx_ready = 1'b1; @(negedge clk); tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort tx_valid", tx_valid, 0);
        chk("abort busy", busy, 0);
        chk("abort no_done", dp_done, 0);
        reset = 1'b1;
        build(8'h4B, 1'b1, 4);
        xfer("restart", 1'b1, wt);
        dp_req = 1'b0;
        chk("restart ipd_wait", wt, IPD_CLKS + 1);

        repeat (3) @(negedge clk);
        chk("hs_done pulses", hs_cnt, 3);
        chk("dp_done pulses", dp_cnt, 5);
        chk("rd_en single_cycle", rd_multi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
- Packet-level TX controller for the USB transceiver byte interface (tx_data/tx_valid/tx_ready).
- Arbitrates between handshake requests (ACK/NAK/STALL) and data-packet requests (DATA0/DATA1 from an endpoint buffer).
- Builds PID byte, streams payload, appends CRC16.
- Enforces inter-packet delay after bus RX activity and after its own packets.

Parameters:
IPD_CLKS, 8, idle clocks required after rx_active falls or own EOP before a new packet starts.
MAX_LEN, 64, maximum payload bytes; sets width of dp_len and rd_addr.

Ports:
clk  in  1  system clock (24 MHz)
reset  in  1  synchronous, active-low reset
rx_active  in  1  transceiver RX busy (between SYNC and EOP)
hs_req  in  1  handshake request, level, held until hs_done
hs_pid  in  4  handshake PID (ACK=0x2, NAK=0xA, STALL=0xE)
hs_done  out  1  one-clock pulse: handshake fully sent
dp_req  in  1  data-packet request, level, held until dp_done
dp_pid  in  4  DATA0=0x3 / DATA1=0xB
dp_len  in  7  payload length 0..MAX_LEN
dp_done  out  1  one-clock pulse: data packet fully sent
rd_addr  out  6  endpoint buffer read address
rd_en  out  1  buffer read strobe; rd_data valid the clock after
rd_data  in  8  buffer read data
tx_data  out  8  byte to transceiver
tx_valid  out  1  rise: SYNC, high: send, fall: EOP
tx_ready  in  1  one-clock pulse: current byte taken
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clk edge) values:
  - tx_valid=0, tx_data=0, hs_done=0, dp_done=0, rd_en=0, rd_addr=0, busy=0.
  - IPD counter loaded with IPD_CLKS (first packet after reset also waits).
  - CRC register=0xFFFF.
- Reset mid-packet: tx_valid drops on the next edge, with no done pulse.
- IPD counter:
  - reloads to IPD_CLKS while rx_active=1, and on the clock tx_valid falls;
  - decrements to 0 otherwise.
  - Packet start requires counter==0 and rx_active==0.
- States:
  - IDLE: when start allowed, hs_req has priority over dp_req. Latch PID/len, CRC:=0xFFFF. Go to SEND_PID with tx_valid=1, tx_data={~pid,pid}.
    - If dp selected and len>0: rd_en=1, rd_addr=0 in the same clock.
  - SEND_PID: on tx_ready:
    - handshake → LAST;
    - data with len==0 → SEND_CRC_LO;
    - else → SEND_DATA, tx_data := prefetched rd_data.
  - SEND_DATA: each presented byte is folded into CRC on the clock it is loaded.
    - On tx_ready: if bytes sent==len → SEND_CRC_LO, else present next byte.
    - Prefetch: rd_en/rd_addr+1 issued on the clock a byte is loaded into tx_data, so the next byte is ready before tx_ready (≥8 bit times).
  - SEND_CRC_LO / SEND_CRC_HI: tx_data = ~crc[7:0], then ~crc[15:8]; advance on tx_ready.
  - LAST: entered on tx_ready of the final byte.
    - Next edge: tx_valid=0, pulse hs_done or dp_done (1 clk), reload IPD, → IDLE.
- CRC16: reflected polynomial 0xA001, init 0xFFFF, LSB-first byte update in one clock, transmitted inverted, low byte first.
- tx_data changes only on the edge after a tx_ready pulse. tx_valid never deasserts mid-packet.
- Requests:
  - A request deasserted after grant is ignored; the packet completes and the done pulse still fires.
  - rx_active rising mid-packet is ignored (the protocol forbids it).
- dp_len>MAX_LEN is clamped to MAX_LEN.
- hs_req and dp_req both pending at start: handshake goes first. The data request is served after the IPD expires.

Decomposition:
- Package usb_pkg (shared with the SIE) holds:
  - pid_t enum (ACK, NAK, STALL, DATA0, DATA1);
  - CRC16_POLY=16'hA001, CRC16_INIT=16'hFFFF;
  - tx_state_t enum.
- One sub-module, usb_crc16: clk, clear, enable, 8-bit data in, 16-bit crc out. Reused later by the RX checker.

Test Plan:
- hs_req=1, hs_pid=ACK, bus idle → after IPD_CLKS, tx_valid rises with tx_data=0xD2. One tx_ready → tx_valid falls next clock, hs_done pulses once.
- dp_req, DATA0, dp_len=0 → bytes C3, 00, 00 in order. dp_done pulses 1 clk after the third tx_ready.
- dp_req, DATA1, len=4, buffer 00 01 02 03 → bytes 4B 00 01 02 03 then CRC lo/hi equal to the golden model. rd_addr sequence 0..3, each rd_en single-cycle.
- rx_active held high for 50 clocks while hs_req=1, NAK → tx_valid stays 0 until IPD_CLKS clocks after rx_active falls, then 0x5A is sent.
- hs_req(STALL) and dp_req(DATA0, len=1) asserted together → 1E sent first. Then ≥IPD_CLKS idle, then C3, d0, crc.
- reset=0 asserted during SEND_DATA → next clock tx_valid=0, busy=0, no done pulse. After release, the pending request restarts from its PID.
